// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage branch hazard sequencer: FSM encodings,
// hazard class codes and the register-zero constant.
package branch_hazard_ctrl_pkg;

    localparam logic STATE_RUN   = 1'b0;
    localparam logic STATE_STALL = 1'b1;

    localparam logic [1:0] HZ_NONE = 2'd0;
    localparam logic [1:0] HZ_MEM  = 2'd1;
    localparam logic [1:0] HZ_ALU  = 2'd2;
    localparam logic [1:0] HZ_LOAD = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hardwired, so a write to it can never feed a branch operand.
    function automatic logic dest_hits(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (rd != REG_ZERO) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating event counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Stall/flush sequencer for branches resolved in ID: freezes PC and IF/ID,
// bubbles ID/EX while branch operands are in flight, flushes IF/ID when taken.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL = 2,
    parameter int ALU_STALL  = 1,
    parameter int MEM_STALL  = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_branch,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             branch_taken,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rd,
    input  logic             ex_mem_mem_read,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_flush,
    output logic             if_id_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic       state;
    logic       next_state;
    logic [1:0] rem;
    logic [1:0] next_rem;
    logic [1:0] hz_class;
    logic [1:0] hz_len;
    logic       hazard;

    // Priority load-in-EX > ALU-in-EX > load-in-MEM: the EX producer is the
    // youngest, so its stall count dominates any older producer.
    always_comb begin
        hz_class = HZ_NONE;
        if (id_branch) begin
            if (id_ex_reg_write && id_ex_mem_read && dest_hits(id_ex_rd, id_rs, id_rt)) begin
                hz_class = HZ_LOAD;
            end else if (id_ex_reg_write && !id_ex_mem_read && dest_hits(id_ex_rd, id_rs, id_rt)) begin
                hz_class = HZ_ALU;
            end else if (ex_mem_mem_read && dest_hits(ex_mem_rd, id_rs, id_rt)) begin
                hz_class = HZ_MEM;
            end
        end
    end

    always_comb begin
        case (hz_class)
            HZ_LOAD: hz_len = 2'(LOAD_STALL);
            HZ_ALU:  hz_len = 2'(ALU_STALL);
            HZ_MEM:  hz_len = 2'(MEM_STALL);
            default: hz_len = 2'd0;
        endcase
    end

    assign hazard = (hz_class != HZ_NONE);

    always_comb begin
        next_state = state;
        next_rem   = rem;
        if (!ext_stall) begin
            if (state == STATE_STALL) begin
                if (rem == 2'd1) begin
                    next_state = STATE_RUN;
                    next_rem   = 2'd0;
                end else begin
                    next_rem = rem - 2'd1;
                end
            end else if (hazard && (hz_len > 2'd1)) begin
                next_state = STATE_STALL;
                next_rem   = hz_len - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_RUN;
            rem   <= 2'd0;
        end else begin
            state <= next_state;
            rem   <= next_rem;
        end
    end

    // A stall always suppresses the taken-branch flush: the comparator saw stale operands.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b0;
        if_id_flush = 1'b0;
        if (!rst && !ext_stall) begin
            if ((state == STATE_STALL) || hazard) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = id_branch && branch_taken;
            end
        end
    end

    assign busy = !rst && (state == STATE_STALL);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (id_ex_flush),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (if_id_flush),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed self-checking bench for branch_hazard_ctrl; a narrow-counter twin
// instance shares all inputs to exercise counter saturation.
module tb_branch_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_branch;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        branch_taken;
    logic        id_ex_reg_write;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic        ext_stall;
    logic        pc_write;
    logic        if_id_write;
    logic        id_ex_flush;
    logic        if_id_flush;
    logic        busy;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        s_pc_write;
    logic        s_if_id_write;
    logic        s_id_ex_flush;
    logic        s_if_id_flush;
    logic        s_busy;
    logic [2:0]  s_stall_cnt;
    logic [2:0]  s_flush_cnt;

    logic [4:0]  ctl;

    int errors;
    int checks;

    branch_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_branch       (id_branch),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .branch_taken    (branch_taken),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .ex_mem_mem_read (ex_mem_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ext_stall       (ext_stall),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_flush     (id_ex_flush),
        .if_id_flush     (if_id_flush),
        .busy            (busy),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    branch_hazard_ctrl #(.CNT_W(3)) dut_narrow (
        .clk             (clk),
        .rst             (rst),
        .id_branch       (id_branch),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .branch_taken    (branch_taken),
        .id_ex_reg_write (id_ex_reg_write),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .ex_mem_mem_read (ex_mem_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ext_stall       (ext_stall),
        .pc_write        (s_pc_write),
        .if_id_write     (s_if_id_write),
        .id_ex_flush     (s_id_ex_flush),
        .if_id_flush     (s_if_id_flush),
        .busy            (s_busy),
        .stall_cnt       (s_stall_cnt),
        .flush_cnt       (s_flush_cnt)
    );

    // Packed view {pc_write, if_id_write, id_ex_flush, if_id_flush, busy}
    assign ctl = {pc_write, if_id_write, id_ex_flush, if_id_flush, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_branch       = 1'b0;
        id_rs           = 5'd0;
        id_rt           = 5'd0;
        branch_taken    = 1'b0;
        id_ex_reg_write = 1'b0;
        id_ex_mem_read  = 1'b0;
        id_ex_rd        = 5'd0;
        ex_mem_mem_read = 1'b0;
        ex_mem_rd       = 5'd0;
        ext_stall       = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        id_branch    = 1'b1;
        branch_taken = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, 5'b00000);
        end
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got %h/%h expected 0000/0000", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b11010) begin
            errors++;
            $display("[TB] FAIL reset_release_ctl: got %b expected %b", ctl, 5'b11010);
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; id_rs = 5'd8; id_rt = 5'd2;
        id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd8;
        #1;
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL load_c1_ctl: got %b expected %b", ctl, 5'b00100);
        end
        @(negedge clk);
        id_ex_reg_write = 1'b0; id_ex_mem_read = 1'b0; id_ex_rd = 5'd0;
        ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd8;
        #1;
        checks++;
        if (ctl !== 5'b00101) begin
            errors++;
            $display("[TB] FAIL load_c2_ctl: got %b expected %b", ctl, 5'b00101);
        end
        @(negedge clk);
        ex_mem_mem_read = 1'b0; ex_mem_rd = 5'd0;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL load_c3_ctl: got %b expected %b", ctl, 5'b11000);
        end
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL load_stall_cnt: got %0d expected %0d", stall_cnt, 2);
        end
    endtask

    task automatic test_alu_stall();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; id_rs = 5'd3; id_rt = 5'd9;
        id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b0; id_ex_rd = 5'd9;
        #1;
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL alu_c1_ctl: got %b expected %b", ctl, 5'b00100);
        end
        @(negedge clk);
        id_ex_reg_write = 1'b0; id_ex_rd = 5'd0;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL alu_c2_ctl: got %b expected %b", ctl, 5'b11000);
        end
        checks++;
        if (stall_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL alu_stall_cnt: got %0d expected %0d", stall_cnt, 1);
        end
    endtask

    task automatic test_mem_and_priority();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; id_rs = 5'd4; id_rt = 5'd1;
        ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd4;
        #1;
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL mem_c1_ctl: got %b expected %b", ctl, 5'b00100);
        end
        @(negedge clk);
        ex_mem_mem_read = 1'b0; ex_mem_rd = 5'd0;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL mem_c2_ctl: got %b expected %b", ctl, 5'b11000);
        end
        // Load in EX and load in MEM together: the 2-cycle class must win.
        @(negedge clk);
        id_rs = 5'd4; id_rt = 5'd5;
        id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd4;
        ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd5;
        #1;
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL prio_c1_ctl: got %b expected %b", ctl, 5'b00100);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl !== 5'b00101) begin
            errors++;
            $display("[TB] FAIL prio_c2_ctl: got %b expected %b", ctl, 5'b00101);
        end
        @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("[TB] FAIL prio_stall_cnt: got %0d expected %0d", stall_cnt, 3);
        end
    endtask

    task automatic test_taken_flush();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd6; id_rt = 5'd7;
        #1;
        checks++;
        if (ctl !== 5'b11010) begin
            errors++;
            $display("[TB] FAIL taken_c1_ctl: got %b expected %b", ctl, 5'b11010);
        end
        @(negedge clk);
        id_branch = 1'b0; branch_taken = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL taken_c2_ctl: got %b expected %b", ctl, 5'b11000);
        end
        checks++;
        if (flush_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL taken_flush_cnt: got %0d expected %0d", flush_cnt, 1);
        end
        @(negedge clk);
        id_branch = 1'b1; branch_taken = 1'b1; id_rs = 5'd0; id_rt = 5'd0;
        id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd0;
        ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd0;
        #1;
        checks++;
        if (ctl !== 5'b11010) begin
            errors++;
            $display("[TB] FAIL reg_zero_ctl: got %b expected %b", ctl, 5'b11010);
        end
        @(negedge clk);
        id_rs = 5'd5; id_rt = 5'd0;
        id_ex_mem_read = 1'b0; id_ex_rd = 5'd5; ex_mem_mem_read = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL hazard_beats_taken_ctl: got %b expected %b", ctl, 5'b00100);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (flush_cnt !== 16'd2 || stall_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL taken_cnts: got %0d/%0d expected 2/1", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_ext_stall();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; id_rs = 5'd8; id_rt = 5'd2;
        id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd8;
        #1;
        checks++;
        if (ctl !== 5'b00100) begin
            errors++;
            $display("[TB] FAIL ext_c1_ctl: got %b expected %b", ctl, 5'b00100);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ext_stall = 1'b1;
            id_branch = 1'b1; branch_taken = 1'b1;
            #1;
            checks++;
            if (ctl !== 5'b00001 || stall_cnt !== 16'd1) begin
                errors++;
                $display("[TB] FAIL ext_freeze_%0d: got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                         i, ctl, stall_cnt, 5'b00001, 1);
            end
        end
        @(negedge clk);
        ext_stall = 1'b0; branch_taken = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00101) begin
            errors++;
            $display("[TB] FAIL ext_resume_ctl: got %b expected %b", ctl, 5'b00101);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (ctl !== 5'b11000 || stall_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL ext_done: got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                     ctl, stall_cnt, 5'b11000, 2);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; id_rs = 5'd8; id_rt = 5'd2;
        id_ex_reg_write = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd8;
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== 5'b00101 || stall_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midrst_pre: got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                     ctl, stall_cnt, 5'b00101, 1);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00000 || stall_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: got ctl=%b cnt=%0d expected ctl=%b cnt=%0d",
                     ctl, stall_cnt, 5'b00000, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (ctl !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL midrst_release_ctl: got %b expected %b", ctl, 5'b11000);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        id_branch = 1'b1; id_rs = 5'd3; id_rt = 5'd9;
        id_ex_reg_write = 1'b1; id_ex_rd = 5'd9;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (s_stall_cnt !== 3'd6 || stall_cnt !== 16'd6) begin
            errors++;
            $display("[TB] FAIL sat_pre: got %0d/%0d expected 6/6", s_stall_cnt, stall_cnt);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (s_stall_cnt !== 3'd7) begin
            errors++;
            $display("[TB] FAIL sat_hold: got %0d expected %0d", s_stall_cnt, 7);
        end
        checks++;
        if (stall_cnt !== 16'd9) begin
            errors++;
            $display("[TB] FAIL sat_wide: got %0d expected %0d", stall_cnt, 9);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_stall();
        test_alu_stall();
        test_mem_and_priority();
        test_taken_flush();
        test_ext_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
